fir_frame_controller: RTL and testbench

- Initiator side of the frame-based FIR filter interface.
- Accepts a serial 8-bit sample stream (valid/ready) and packs FRAME_LEN samples into a parallel frame buffer that drives the filter's frame input.
- Pulses the filter start, waits for filter ready, snapshots the filtered frame, then drains it as a serial stream with an end-of-frame marker.
- The input and output buffers are separate, so loading of frame N+1 overlaps draining of frame N.

---
 rtl/fir_pkg.sv | 10 +
 rtl/fir_frame_drain.sv | 50 +++++
 rtl/fir_frame_controller.sv | 98 +++++++++
 tb/tb_fir_frame_controller.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and defaults for the frame-based FIR filter and its controller.
package fir_pkg;
    localparam int FIR_FRAME_LEN = 256;
    localparam int FIR_DW        = 8;

    typedef enum logic [1:0] {LOAD, START, WAIT} in_state_e;

    typedef logic [FIR_DW-1:0]           sample_t;
    typedef sample_t [FIR_FRAME_LEN-1:0] frame_t;
endpackage

// File: rtl/fir_frame_drain.sv
// Output side: holds one snapshotted filter frame and streams it out with a last marker.
module fir_frame_drain
    import fir_pkg::*;
#(
    parameter int FRAME_LEN = FIR_FRAME_LEN,
    parameter int DW        = FIR_DW
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [FRAME_LEN-1:0][DW-1:0]  load_frame,
    output logic                          out_full,
    output logic [DW-1:0]                 m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last
);
    localparam int IW = $clog2(FRAME_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

    logic [FRAME_LEN-1:0][DW-1:0] out_buf;
    logic [IW-1:0]                rd_idx;
    logic                         beat;

    assign beat = out_full && m_ready;

    // load is only ever raised while out_full is low, so it never collides with a beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_buf  <= '0;
            rd_idx   <= '0;
            out_full <= 1'b0;
        end else if (load) begin
            out_buf  <= load_frame;
            rd_idx   <= '0;
            out_full <= 1'b1;
        end else if (beat) begin
            if (rd_idx == LAST_IDX) begin
                rd_idx   <= '0;
                out_full <= 1'b0;
            end else begin
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

    assign m_valid = out_full;
    assign m_data  = out_buf[rd_idx];
    assign m_last  = out_full && (rd_idx == LAST_IDX);
endmodule

// File: rtl/fir_frame_controller.sv
// Initiator for the frame FIR filter: packs a serial stream into a frame, starts the
// filter, snapshots its result once ready is trusted, and hands it to the drain side.
module fir_frame_controller
    import fir_pkg::*;
#(
    parameter int FRAME_LEN = FIR_FRAME_LEN,
    parameter int DW        = FIR_DW,
    parameter int MIN_WAIT  = 1,
    parameter int TIMEOUT   = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DW-1:0]                 s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [FRAME_LEN-1:0][DW-1:0]  filt_frame,
    output logic                          filt_start,
    input  logic                          filt_rdy,
    input  logic [FRAME_LEN-1:0][DW-1:0]  filt_result,
    output logic [DW-1:0]                 m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic                          busy,
    output logic                          timeout_err
);
    localparam int IW = $clog2(FRAME_LEN);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] MIN_CNT  = CW'(MIN_WAIT);
    localparam logic [CW-1:0] MAX_CNT  = CW'(TIMEOUT);

    in_state_e     state, state_nxt;
    logic [IW-1:0] wr_idx;
    logic [CW-1:0] wait_cnt;
    logic          out_full;
    logic          accept;
    logic          snapshot;
    logic          expire;

    // filt_rdy is sticky, so it is only trusted after MIN_WAIT cycles past the start pulse
    assign s_ready    = (state == LOAD) && rst_n;
    assign filt_start = (state == START);
    assign accept     = s_valid && s_ready;
    assign snapshot   = (state == WAIT) && (wait_cnt >= MIN_CNT) && filt_rdy && !out_full;
    assign expire     = (state == WAIT) && (wait_cnt >= MAX_CNT) && !filt_rdy && !out_full;
    assign busy       = (state != LOAD) || (wr_idx != '0) || out_full;

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (s_valid && (wr_idx == LAST_IDX)) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (snapshot || expire) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_frame  <= '0;
            wr_idx      <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                filt_frame[wr_idx] <= s_data;
                wr_idx             <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
            end
            if (state == START)
                wait_cnt <= '0;
            else if ((state == WAIT) && (wait_cnt != MAX_CNT))
                wait_cnt <= wait_cnt + 1'b1;
            if (expire)
                timeout_err <= 1'b1;
        end
    end

    fir_frame_drain #(
        .FRAME_LEN (FRAME_LEN),
        .DW        (DW)
    ) u_drain (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (snapshot),
        .load_frame (filt_result),
        .out_full   (out_full),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
    );
endmodule

// File: tb/tb_fir_frame_controller.sv
// Directed bench for fir_frame_controller with a behavioural sticky-ready filter model.
module tb_fir_frame_controller;
    import fir_pkg::*;

    localparam int FL       = FIR_FRAME_LEN;
    localparam int MIN_WAIT = 1;
    localparam int TIMEOUT  = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    frame_t     filt_frame;
    logic       filt_start;
    logic       filt_rdy = 1'b0;
    frame_t     filt_result = '0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       m_last;
    logic       busy;
    logic       timeout_err;
    logic       filt_en = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int starts = 0;
    int start_cyc = 0;

    fir_frame_controller #(
        .FRAME_LEN (FL),
        .DW        (FIR_DW),
        .MIN_WAIT  (MIN_WAIT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .filt_frame  (filt_frame),
        .filt_start  (filt_start),
        .filt_rdy    (filt_rdy),
        .filt_result (filt_result),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fx(input logic [7:0] x);
        return 8'(x * 3 + 7);
    endfunction

    function automatic logic [7:0] pat(input int kind, input int i);
        case (kind)
            0:       return 8'(i);
            1:       return 8'(255 - i);
            2:       return 8'(i) ^ 8'h5A;
            3:       return 8'(i * 7 + 1);
            default: return 8'(i + kind * 13);
        endcase
    endfunction

    function automatic logic [7:0] expv(input int kind, input int i);
        return fx(pat(kind, i));
    endfunction

    always @(posedge clk) begin
        if (filt_start) begin
            starts++;
            start_cyc = cyc;
        end
        cyc++;
    end

    // Filter model: result and sticky ready appear half a cycle after the start pulse
    always @(negedge clk) begin
        if (!filt_en) begin
            filt_rdy = 1'b0;
        end else if (filt_start) begin
            for (int i = 0; i < FL; i++) filt_result[i] = fx(filt_frame[i]);
            filt_rdy = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input int kind, input int count);
        int n;
        n = 0;
        for (int i = 0; i < count; i++) begin
            s_data  = pat(kind, i);
            s_valid = 1'b1;
            while (!s_ready && n < 5000) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("feed_bound", 32'(n < 5000), 1);
    endtask

    task automatic wait_valid(input string tag, input int lat);
        int n;
        n = 0;
        while (!m_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_seen"}, 32'(m_valid), 1);
        chk({tag, "_lat"}, 32'(cyc - start_cyc), 32'(lat));
    endtask

    task automatic drain(input int kind, input bit toggle, input string tag);
        int   b;
        int   n;
        logic r;
        b = 0;
        n = 0;
        while (b < FL && n < 4000) begin
            r = toggle ? ~n[0] : 1'b1;
            m_ready = r;
            if (m_valid) begin
                chk({tag, "_data"}, 32'(m_data), 32'(expv(kind, b)));
                chk({tag, "_last"}, 32'(m_last), 32'(b == FL - 1));
                if (r) b++;
            end
            @(negedge clk);
            n++;
        end
        m_ready = 1'b0;
        chk({tag, "_count"}, 32'(b), 32'(FL));
    endtask

    initial begin
        int   n;
        int   base;
        logic any_v;

        #2;
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_filt_start", 32'(filt_start), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("load_s_ready", 32'(s_ready), 1);

        // ramp frame
        feed(0, FL);
        chk("ramp_start", 32'(filt_start), 1);
        chk("ramp_s_ready_start", 32'(s_ready), 0);
        chk("ramp_busy", 32'(busy), 1);
        chk("ramp_frame0", 32'(filt_frame[0]), 32'h00);
        chk("ramp_frame255", 32'(filt_frame[255]), 32'hFF);
        wait_valid("ramp", MIN_WAIT + 2);
        chk("ramp_starts", 32'(starts), 1);
        chk("ramp_first", 32'(m_data), 32'h07);
        drain(0, 1'b0, "ramp");
        chk("ramp_busy_after", 32'(busy), 0);
        chk("ramp_valid_after", 32'(m_valid), 0);

        // backpressure, with ready still sticky from the previous frame
        feed(1, FL);
        chk("sticky_start", 32'(filt_start), 1);
        chk("sticky_rdy_high", 32'(filt_rdy), 1);
        wait_valid("sticky", MIN_WAIT + 2);
        drain(1, 1'b1, "bp");

        // overlap: frame B waits while frame A is held undrained
        feed(2, FL);
        wait_valid("ovl_a", MIN_WAIT + 2);
        feed(3, FL);
        chk("ovl_b_start", 32'(filt_start), 1);
        s_valid = 1'b1;
        s_data  = 8'hEE;
        for (int i = 0; i < 20; i++) @(negedge clk);
        s_valid = 1'b0;
        chk("ovl_hold_s_ready", 32'(s_ready), 0);
        chk("ovl_hold_busy", 32'(busy), 1);
        chk("ovl_hold_valid", 32'(m_valid), 1);
        chk("ovl_a_data", 32'(m_data), 32'(expv(2, 0)));
        chk("ovl_b_frame0", 32'(filt_frame[0]), 32'(pat(3, 0)));
        chk("ovl_b_frame255", 32'(filt_frame[255]), 32'(pat(3, 255)));
        chk("ovl_starts", 32'(starts), 4);
        drain(2, 1'b0, "ovl_a");
        chk("ovl_gap_valid", 32'(m_valid), 0);
        @(negedge clk);
        chk("ovl_b_valid", 32'(m_valid), 1);
        chk("ovl_b_first", 32'(m_data), 32'(expv(3, 0)));
        drain(3, 1'b0, "ovl_b");
        chk("ovl_busy_after", 32'(busy), 0);

        // timeout: filter never becomes ready
        filt_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        feed(4, FL);
        chk("to_start", 32'(filt_start), 1);
        any_v = 1'b0;
        n = 0;
        while (!timeout_err && n < 3000) begin
            if (m_valid) any_v = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("to_err", 32'(timeout_err), 1);
        chk("to_lat", 32'(cyc - start_cyc), 32'(TIMEOUT + 2));
        chk("to_s_ready", 32'(s_ready), 1);
        chk("to_valid_seen", 32'(any_v), 0);
        chk("to_valid", 32'(m_valid), 0);
        chk("to_busy", 32'(busy), 0);
        chk("to_frame_kept", 32'(filt_frame[5]), 32'(pat(4, 5)));

        // reset in the middle of a load
        filt_en = 1'b1;
        @(negedge clk);
        feed(5, 100);
        chk("mid_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s_ready", 32'(s_ready), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_timeout_err", 32'(timeout_err), 0);
        chk("mid_rst_m_valid", 32'(m_valid), 0);
        chk("mid_rst_m_data", 32'(m_data), 0);
        chk("mid_rst_filt_start", 32'(filt_start), 0);
        chk("mid_rst_frame", 32'(filt_frame[50]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = starts;
        feed(6, FL);
        wait_valid("post_rst", MIN_WAIT + 2);
        chk("post_rst_starts", 32'(starts - base), 1);
        drain(6, 1'b0, "post_rst");
        chk("post_rst_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
